// File: rtl/fifo_rd_packer_if.sv
// Bundles the FIFO read port and the packed-word output stream of fifo_rd_packer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if #(
  parameter int DATA_W = 8,
  parameter int NBYTES = 4
);
  logic                     fifo_empty;
  logic [DATA_W-1:0]        fifo_rd_data;
  logic                     fifo_rd_en;
  logic [DATA_W*NBYTES-1:0] out_data;
  logic [NBYTES-1:0]        out_keep;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_data, out_keep, out_last, out_valid
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_data, out_keep, out_last, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side byte packer: pops FIFO bytes and packs NBYTES of them little-endian
// into words on a valid/ready stream; flush emits a partial word with keep/last.
module fifo_rd_packer #(
  parameter int DATA_W = 8,
  parameter int NBYTES = 4
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  fifo_rd_packer_if.master  bus,
  input  logic              flush,
  output logic              busy
);
  localparam int WORD_W = DATA_W * NBYTES;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  typedef enum logic [0:0] {ACCUM, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [WORD_W-1:0]   acc_reg, acc_next;
  logic                flush_pend_reg, flush_pend_next;
  logic [WORD_W-1:0]   out_data_reg, out_data_next;
  logic [NBYTES-1:0]   out_keep_reg, out_keep_next;
  logic                out_last_reg, out_last_next;
  logic                out_valid_reg, out_valid_next;

  logic                slot_free;
  logic                pop;
  logic [WORD_W-1:0]   acc_with_byte;
  logic [NBYTES-1:0]   partial_keep;

  // Per-lane view: accumulator with the head byte dropped into lane cnt,
  // and the keep mask covering lanes below cnt.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign acc_with_byte[gi*DATA_W +: DATA_W] =
      (cnt_reg == CNT_W'(gi)) ? bus.fifo_rd_data : acc_reg[gi*DATA_W +: DATA_W];
    assign partial_keep[gi] = (CNT_W'(gi) < cnt_reg);
  end

  always_comb begin
    slot_free = !out_valid_reg || bus.out_ready;
    // The completing byte may only pop when the output slot can take the word.
    pop = (state_reg == ACCUM) && !bus.fifo_empty && !flush_pend_reg &&
          ((cnt_reg != LAST_CNT) || slot_free);

    state_next      = state_reg;
    cnt_next        = cnt_reg;
    acc_next        = acc_reg;
    flush_pend_next = flush_pend_reg;
    out_data_next   = out_data_reg;
    out_keep_next   = out_keep_reg;
    out_last_next   = out_last_reg;
    out_valid_next  = out_valid_reg && !bus.out_ready;

    case (state_reg)
      ACCUM: begin
        if (pop) begin
          if (cnt_reg == LAST_CNT) begin
            out_data_next  = acc_with_byte;
            out_keep_next  = '1;
            out_last_next  = 1'b0;
            out_valid_next = 1'b1;
            cnt_next       = '0;
            acc_next       = '0;
          end else begin
            acc_next = acc_with_byte;
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        if (flush) begin
          flush_pend_next = 1'b1;
          state_next      = FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          // Unfilled lanes are already zero because acc is cleared on every word.
          if (cnt_reg != '0) begin
            out_data_next  = acc_reg;
            out_keep_next  = partial_keep;
            out_last_next  = 1'b1;
            out_valid_next = 1'b1;
            cnt_next       = '0;
            acc_next       = '0;
          end
          flush_pend_next = 1'b0;
          state_next      = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_reg      <= ACCUM;
      cnt_reg        <= '0;
      acc_reg        <= '0;
      flush_pend_reg <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      acc_reg        <= acc_next;
      flush_pend_reg <= flush_pend_next;
      out_data_reg   <= out_data_next;
      out_keep_reg   <= out_keep_next;
      out_last_reg   <= out_last_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_data   = out_data_reg;
  assign bus.out_keep   = out_keep_reg;
  assign bus.out_last   = out_last_reg;
  assign bus.out_valid  = out_valid_reg;
  assign busy           = (cnt_reg != '0) || flush_pend_reg || out_valid_reg;
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side stage directly downstream of the async FIFO, in the rd_clk domain.
- Pops bytes from the FIFO read port and packs NBYTES consecutive bytes little-endian into one output word.
- Presents each word on a valid/ready stream, with a flush input that emits a partial word carrying byte-keep and last flags.
- Sustains one pop per cycle while the consumer keeps out_ready high.

Parameters:
DATA_W, 8, FIFO byte width; must equal the FIFO data width.
NBYTES, 4, bytes per output word; legal range 2..8.

Ports:
rd_clk  input  1  read-domain clock; all state updates on its rising edge.
rd_rst  input  1  asynchronous active-high reset; pass the synchronised read reset.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_data  input  DATA_W  FIFO head byte; valid combinationally while fifo_empty=0.
fifo_rd_en  output  1  pop request to FIFO (combinational).
flush  input  1  single-cycle request to emit the current partial word.
out_data  output  DATA_W*NBYTES  packed word; first-popped byte in bits [DATA_W-1:0].
out_keep  output  NBYTES  byte valid mask for out_data.
out_last  output  1  set on a word produced by flush.
out_valid  output  1  output word valid.
out_ready  input  1  consumer accepts the word when out_valid=1 at the rising edge.
busy  output  1  cnt!=0, or flush_pend=1, or out_valid=1.

Behaviour:
- Interface: one clock (rd_clk); reset rd_rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - Internal accumulator acc=0, byte count cnt=0, flush_pend=0, state=ACCUM.
- Reset mid-operation discards accumulated bytes and any held output word. Bytes not yet popped stay in the FIFO.
- Output slot definitions:
  - slot_free = !out_valid || out_ready.
  - An output word changes only when slot_free=1.
  - While out_valid=1 and out_ready=0, out_data, out_keep and out_last hold stable.
- State ACCUM:
  - fifo_rd_en = !fifo_empty && !flush_pend && (cnt<NBYTES-1 || slot_free).
  - On a pop: acc[cnt*DATA_W +: DATA_W] <= fifo_rd_data, and cnt increments.
  - When the pop fills the word (cnt==NBYTES-1), on the same edge:
    - out_data <= completed word, out_keep <= all ones, out_last <= 0, out_valid <= 1.
    - cnt <= 0 and acc cleared.
  - Result: a full word is visible on out_valid one cycle after its last byte pops.
  - Without a pop, a held word is consumed when out_ready=1, so out_valid <= 0.
- Flush request:
  - flush=1 in ACCUM sets flush_pend, and the state moves to FLUSH on the next edge.
  - A pop in the same cycle as flush still occurs; that byte is included in the flushed word.
  - flush while flush_pend=1 or in FLUSH is ignored.
- State FLUSH:
  - fifo_rd_en=0.
  - Waits for slot_free=1. At that edge:
    - If cnt>0: out_data <= acc, with unfilled byte lanes zero.
    - If cnt>0: out_keep <= (1<<cnt)-1, out_last <= 1, out_valid <= 1.
    - If cnt>0: cnt <= 0 and acc cleared.
    - If cnt==0: no word is emitted; a held word, if any, is consumed normally.
  - In both cases flush_pend <= 0 and the state returns to ACCUM.
- Boundary conditions:
  - A flush that lands exactly on word completion: the full word goes out with last=0. FLUSH then finds cnt==0 and emits nothing.
  - fifo_empty=1 forces fifo_rd_en=0 under all conditions; the block never pops an empty FIFO.
  - cnt never exceeds NBYTES-1 between edges; the count wraps to 0 on word completion.
- Throughput and latency:
  - 1 byte per cycle with out_ready held high.
  - One word every NBYTES cycles.
  - First-byte-to-out_valid latency is NBYTES cycles.

Test Plan:
- Reset then 8 bytes 0x01..0x08 with out_ready=1 -> words 0x04030201 then 0x08070605, keep=0xF, last=0, fifo_rd_en high for 8 consecutive cycles.
- 3 bytes 0xAA,0xBB,0xCC then flush pulse -> one word 0x00CCBBAA, keep=0x7, last=1; busy returns to 0 the cycle after acceptance.
- out_ready=0 after the first word with 8 bytes queued -> 3 more bytes pop, then fifo_rd_en=0 and out_data holds 0x04030201; raising out_ready resumes popping at 1/cycle with no byte lost or duplicated.
- Flush in the same cycle as the 4th pop of a word -> full word with last=0, no extra output word; flush with cnt=0 and idle -> no output.
- Assert rd_rst mid-word after 2 pops -> out_valid=0 immediately; after release, the next 4 FIFO bytes form a clean word at lane 0.
- fifo_empty toggling every cycle for a 12-byte stream -> fifo_rd_en never asserted while empty; words emitted in the correct order.
